// File: rtl/conv_out_requant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_out_requant
// Purpose  : Last stage of the conv accelerator output path. It takes one
//            frame of signed accumulator values, adds a per-frame bias, applies
//            a rounding arithmetic right shift, then ReLU and an unsigned
//            clamp. It emits WIDTH*HEIGHT WO-bit pixels on a valid-only
//            stream with no backpressure.
// Ports    : clk, rstn          clock, asynchronous active-low reset
//            start, bias        frame start pulse, per-frame bias (latched)
//            din, din_vld       accumulator input; din_rdy is its ready
//            dout, vld          requantized pixel and its valid
//            frame_done         one-cycle pulse on the final pixel of a frame
//            busy               frame in progress (RUN or FLUSH)
//            sat_cnt            clamped-pixel count (only with the macro)
// Options  : define CONV_OUT_SAT_CNT_EN to add the sat_cnt counter port
// Revision : 1.0 - initial release
// ============================================================================
module conv_out_requant #(
  parameter int WA     = 20,
  parameter int WO     = 8,
  parameter int SHIFT  = 7,
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [WA-1:0] bias,
  input  logic [WA-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic [WO-1:0] dout,
  output logic          vld,
  output logic          frame_done,
  output logic          busy
`ifdef CONV_OUT_SAT_CNT_EN
  ,
  output logic [15:0]   sat_cnt
`endif
);

  localparam int c_NPIX = WIDTH * HEIGHT;
  localparam int c_CW   = $clog2(c_NPIX + 1);
  // Two guard bits: one for the bias add, one for the rounding constant.
  localparam int c_WS   = WA + 2;
  localparam logic [c_CW-1:0]        c_LAST = c_CW'(c_NPIX - 1);
  localparam logic signed [c_WS-1:0] c_MAX  = {{(c_WS-WO){1'b0}}, {WO{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_CW-1:0]          r_cnt;
  logic [WA-1:0]            r_bias;
  logic signed [c_WS-1:0]   r_s1;
  logic                     r_s1_vld;
  logic                     r_s1_last;
  logic [WO-1:0]            r_dout;
  logic                     r_vld;
  logic                     r_done;

  logic                     w_start_acc;
  logic                     w_accept;
  logic                     w_last_acc;
  logic signed [c_WS-1:0]   w_sum;
  logic signed [c_WS-1:0]   w_round;
  logic                     w_neg;
  logic                     w_hi;
  logic [WO-1:0]            w_clamp;

  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_accept    = din_vld && (r_state == S_RUN);
  assign w_last_acc  = w_accept && (r_cnt == c_LAST);

  assign din_rdy    = (r_state == S_RUN);
  assign busy       = (r_state != S_IDLE);
  assign dout       = r_dout;
  assign vld        = r_vld;
  assign frame_done = r_done;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_state_nxt = S_RUN;
      S_RUN:   if (w_last_acc) w_state_nxt = S_FLUSH;
      // Leave FLUSH in the same cycle the last pixel is presented.
      S_FLUSH: if (r_done)     w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_bias <= '0;
    end else if (w_start_acc) begin
      r_cnt  <= '0;
      r_bias <= bias;
    end else if (w_accept) begin
      r_cnt  <= r_cnt + c_CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: bias add and rounding shift
  // --------------------------------------------------------------------------
  assign w_sum = $signed({{2{din[WA-1]}}, din}) + $signed({{2{r_bias[WA-1]}}, r_bias});

  generate
    if (SHIFT > 0) begin : g_round
      // Adding half an LSB before the arithmetic shift rounds half toward +inf.
      localparam logic signed [c_WS-1:0] c_HALF = {{(c_WS-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign w_round = (w_sum + c_HALF) >>> SHIFT;
    end else begin : g_noround
      assign w_round = w_sum;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1      <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_last <= w_last_acc;
      if (w_accept) begin
        r_s1 <= w_round;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: ReLU and unsigned clamp
  // --------------------------------------------------------------------------
  assign w_neg   = r_s1[c_WS-1];
  assign w_hi    = !w_neg && (r_s1 > c_MAX);
  assign w_clamp = w_neg ? '0 : (w_hi ? {WO{1'b1}} : r_s1[WO-1:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_vld  <= r_s1_vld;
      r_done <= r_s1_last;
      if (r_s1_vld) begin
        r_dout <= w_clamp;
      end
    end
  end

`ifdef CONV_OUT_SAT_CNT_EN
  logic [15:0] r_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sat <= '0;
    end else if (w_start_acc) begin
      r_sat <= '0;
    end else if (r_s1_vld && (w_neg || w_hi) && (r_sat != 16'hFFFF)) begin
      r_sat <= r_sat + 16'd1;
    end
  end

  assign sat_cnt = r_sat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_out_requant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_out_requant
// Purpose  : Scoreboard bench for conv_out_requant with a 4x2 frame. The
//            driver pushes hand-computed expected pixels as it presents them;
//            a negedge monitor pops and compares whenever vld is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_out_requant;

  localparam int WA = 20;
  localparam int WO = 8;
  localparam int SH = 7;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int NP = FW * FH;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [WA-1:0] bias = '0;
  logic [WA-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic [WO-1:0] dout;
  logic          vld;
  logic          frame_done;
  logic          busy;
`ifdef CONV_OUT_SAT_CNT_EN
  logic [15:0]   sat_cnt;
`endif

  conv_out_requant #(
    .WA(WA), .WO(WO), .SHIFT(SH), .WIDTH(FW), .HEIGHT(FH)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .bias(bias),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .vld(vld), .frame_done(frame_done), .busy(busy)
`ifdef CONV_OUT_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int q_d[$];
  int q_fd[$];
  int q_cyc[$];
  bit busy_chk = 1'b0;
  int tv[NP];
  int te[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented pixel against the scoreboard.
  always @(negedge clk) begin
    int d, fd, c;
    if (rstn) begin
      if (busy_chk) begin
        chk("busy_after_done", busy, 0);
        busy_chk = 1'b0;
      end
      if (vld) begin
        if (q_d.size() == 0) begin
          chk("unexpected_vld", vld, 0);
        end else begin
          d  = q_d.pop_front();
          fd = q_fd.pop_front();
          c  = q_cyc.pop_front();
          chk("dout", dout, d);
          chk("frame_done", frame_done, fd);
          chk("latency", cyc - c, 2);
          if (frame_done) busy_chk = 1'b1;
        end
      end else if (frame_done) begin
        chk("frame_done_without_vld", frame_done, 0);
      end
    end
  end

  task automatic do_reset_checks();
    chk("rst_dout", dout, 0);
    chk("rst_vld", vld, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_busy", busy, 0);
`ifdef CONV_OUT_SAT_CNT_EN
    chk("rst_sat_cnt", sat_cnt, 0);
`endif
  endtask

  // Runs one frame from tv/te. gaps inserts an idle cycle after each input,
  // abort_at asserts reset before that input index, mid_start_at pulses a
  // second start (different bias) while the frame is running.
  task automatic run_frame(input int b, input bit gaps, input int abort_at,
                           input int mid_start_at, input int exp_sat);
    int n;
    @(posedge clk); #1;
    start = 1'b1;
    bias  = WA'(b);
    @(posedge clk); #1;
    start = 1'b0;
    bias  = WA'(12345);
    for (int i = 0; i < NP; i++) begin
      if (i == abort_at) begin
        rstn    = 1'b0;
        din_vld = 1'b0;
        q_d.delete();
        q_fd.delete();
        q_cyc.delete();
        busy_chk = 1'b0;
        #1;
        do_reset_checks();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      din     = WA'(tv[i]);
      din_vld = 1'b1;
      if (i == mid_start_at) begin
        start = 1'b1;
        bias  = WA'(5000);
      end
      chk("din_rdy_run", din_rdy, 1);
      chk("busy_run", busy, 1);
      q_d.push_back(te[i]);
      q_fd.push_back(int'(i == NP - 1));
      q_cyc.push_back(cyc);
      @(posedge clk); #1;
      start = 1'b0;
      if (gaps) begin
        din_vld = 1'b0;
        @(posedge clk); #1;
      end
    end
    // One surplus value: must not be consumed.
    din     = WA'(777);
    din_vld = 1'b1;
    chk("din_rdy_after_last", din_rdy, 0);
    @(posedge clk); #1;
    din_vld = 1'b0;
    n = 0;
    while ((q_d.size() != 0 || busy) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_drained", q_d.size(), 0);
    chk("idle_after_frame", busy, 0);
`ifdef CONV_OUT_SAT_CNT_EN
    chk("sat_cnt", sat_cnt, exp_sat);
`else
    if (exp_sat < 0) chk("sat_arg", exp_sat, 0);
`endif
  endtask

  initial begin
    #2;
    do_reset_checks();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    do_reset_checks();

    // Bias 0, continuous input, rounding boundaries.
    tv = '{1000, 64, 63, 0, 191, 192, -64, -65};
    te = '{8, 1, 0, 0, 1, 2, 0, 0};
    run_frame(0, 1'b0, -1, -1, 1);

    // Bias -2000, input bubbles, ReLU and high clamp.
    tv = '{1000, 100000, 3280, 3344, 2063, 2064, -100000, 34640};
    te = '{0, 255, 10, 11, 0, 1, 0, 255};
    run_frame(-2000, 1'b1, -1, -1, 3);

    // Start pulse during RUN must not relatch bias or restart counting.
    tv = '{128, 256, 384, 512, 640, 768, 896, 1024};
    te = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(0, 1'b0, -1, 2, 0);

    // Reset after three accepts.
    tv = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    te = '{8, 8, 8, 8, 8, 8, 8, 8};
    run_frame(0, 1'b0, 3, -1, 0);
    @(posedge clk); #1;
    chk("idle_after_abort", busy, 0);

    // Full frame after the abort, bias 100.
    tv = '{-36, -37, -164, -165, 32540, 32541, 32604, 924};
    te = '{1, 0, 0, 0, 255, 255, 255, 8};
    run_frame(100, 1'b0, -1, -1, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
